// File: rtl/unmask_sequencer_pkg.sv
// Shared types for unmask_sequencer: the sequencer state encoding.
package unmask_sequencer_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/unmask_sequencer_reduce_xor.sv
// reduce_xor: combinational XOR of NUM_ELEMENTS equal-width elements.
module reduce_xor #(
  parameter int NUM_ELEMENTS  = 2,
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic [NUM_ELEMENTS-1:0][ELEMENT_WIDTH-1:0] elements_i,
  output logic [ELEMENT_WIDTH-1:0]                   result_o
);

  always_comb begin
    result_o = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      result_o = result_o ^ elements_i[i];
    end
  end

endmodule

// File: rtl/unmask_sequencer.sv
// Serially collects NUM_SHARES shares, recombines them in one registered XOR stage.
// Optional macro UNMASK_SEQUENCER_ZEROIZE_EN clears buffer and result after each output handshake.
module unmask_sequencer
  import unmask_sequencer_pkg::*;
#(
  parameter int NUM_SHARES    = 3,
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic [ELEMENT_WIDTH-1:0] in_share,
  input  logic                     in_share_valid,
  output logic                     out_share_ready,
  output logic [ELEMENT_WIDTH-1:0] out_value,
  output logic                     out_value_valid,
  input  logic                     in_value_ready,
  output logic                     out_busy,
  output logic [1:0]               out_dbg_state
);

  localparam int CNT_W = $clog2(NUM_SHARES + 1);

  typedef logic [ELEMENT_WIDTH-1:0] element_t;
  typedef element_t [NUM_SHARES-1:0] share_array_t;

  // Handshakes: a share transfers when in_share_valid & out_share_ready at a rising
  // edge; the result transfers when out_value_valid & in_value_ready at a rising edge.
  // A holder of valid keeps its data stable until the transfer happens.

  state_t       state_q;
  logic [CNT_W-1:0] count_q;
  share_array_t buffer_q;
  element_t     value_q;
  logic         valid_q;
  logic         share_ready_q;
  element_t     reduced;

  reduce_xor #(
    .NUM_ELEMENTS  (NUM_SHARES),
    .ELEMENT_WIDTH (ELEMENT_WIDTH)
  ) u_reduce_xor (
    .elements_i (buffer_q),
    .result_o   (reduced)
  );

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q       <= COLLECT;
      count_q       <= '0;
      buffer_q      <= '0;
      value_q       <= '0;
      valid_q       <= 1'b0;
      share_ready_q <= 1'b1;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_share_valid && share_ready_q) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
              if (count_q == CNT_W'(i)) buffer_q[i] <= in_share;
            end
            if (count_q == CNT_W'(NUM_SHARES - 1)) begin
              count_q       <= '0;
              state_q       <= REDUCE;
              share_ready_q <= 1'b0;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        REDUCE: begin
          // Shares meet only here, after the full set has been buffered.
          value_q <= reduced;
          valid_q <= 1'b1;
          state_q <= OUTPUT;
        end
        OUTPUT: begin
          if (in_value_ready) begin
            valid_q       <= 1'b0;
            share_ready_q <= 1'b1;
            state_q       <= COLLECT;
`ifdef UNMASK_SEQUENCER_ZEROIZE_EN
            buffer_q      <= '0;
            value_q       <= '0;
`endif
          end
        end
        default: begin
          state_q       <= COLLECT;
          count_q       <= '0;
          valid_q       <= 1'b0;
          share_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_share_ready = share_ready_q;
  assign out_value       = value_q;
  assign out_value_valid = valid_q;
  assign out_busy        = (state_q != COLLECT) || (count_q != '0);
  assign out_dbg_state   = state_q;

endmodule

// File: tb/tb_unmask_sequencer.sv
// Self-checking bench for unmask_sequencer: vector table, hand sequences, random vs. scoreboard.
module tb_unmask_sequencer;

`ifdef UNMASK_SEQUENCER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       in_reset = 1'b1;
  logic [7:0] in_share = '0;
  logic       in_share_valid = 1'b0;
  logic       in_value_ready = 1'b1;
  logic       out_share_ready, out_value_valid, out_busy;
  logic [7:0] out_value;
  logic [1:0] out_dbg_state;

  logic [7:0] share2 = '0;
  logic       share_valid2 = 1'b0;
  logic       value_ready2 = 1'b1;
  logic       share_ready2, value_valid2, busy2;
  logic [7:0] value2;
  logic [1:0] dbg_state2;

  unmask_sequencer #(.NUM_SHARES(3), .ELEMENT_WIDTH(8)) dut (
    .in_clock(clk), .in_reset(in_reset), .in_share(in_share),
    .in_share_valid(in_share_valid), .out_share_ready(out_share_ready),
    .out_value(out_value), .out_value_valid(out_value_valid),
    .in_value_ready(in_value_ready), .out_busy(out_busy), .out_dbg_state(out_dbg_state)
  );

  unmask_sequencer #(.NUM_SHARES(2), .ELEMENT_WIDTH(8)) dut2 (
    .in_clock(clk), .in_reset(in_reset), .in_share(share2),
    .in_share_valid(share_valid2), .out_share_ready(share_ready2),
    .out_value(value2), .out_value_valid(value_valid2),
    .in_value_ready(value_ready2), .out_busy(busy2), .out_dbg_state(dbg_state2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit second, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((second ? value_valid2 : out_value_valid) === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] share;
    logic       sv;
    logic       vr;
    logic       rst;
    logic       e_ready;
    logic       e_valid;
    logic       e_busy;
    logic [7:0] e_value;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [7:0] sh, input logic sv, input logic vr, input logic rst,
                              input logic er, input logic ev, input logic eb, input logic [7:0] eval);
    vec_t v;
    v.share = sh; v.sv = sv; v.vr = vr; v.rst = rst;
    v.e_ready = er; v.e_valid = ev; v.e_busy = eb; v.e_value = eval;
    vecs.push_back(v);
  endfunction

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] group[$];

  initial begin
    logic [7:0] zv96, zv07, zve0, acc_x;
    bit ok, pending, prev_valid, prev_hs, acc, hs;
    logic [7:0] prev_value;
    int t_last;

    zv96 = ZEROIZE ? 8'h00 : 8'h96;
    zv07 = ZEROIZE ? 8'h00 : 8'h07;
    zve0 = ZEROIZE ? 8'h00 : 8'hE0;

    // basic recombination, then backpressure with a share offered meanwhile
    add(8'hA5,1,1,0, 1,0,0,8'h00);
    add(8'h3C,1,1,0, 1,0,1,8'h00);
    add(8'h0F,1,1,0, 1,0,1,8'h00);
    add(8'h00,0,1,0, 0,0,1,8'h00);
    add(8'h00,0,1,0, 0,1,1,8'h96);
    add(8'h00,0,1,0, 1,0,0,zv96);
    add(8'hA5,1,0,0, 1,0,0,zv96);
    add(8'h3C,1,0,0, 1,0,1,zv96);
    add(8'h0F,1,0,0, 1,0,1,zv96);
    add(8'h55,1,0,0, 0,0,1,zv96);
    for (int i = 0; i < 5; i++) add(8'h55,1,0,0, 0,1,1,8'h96);
    add(8'h55,1,1,0, 0,1,1,8'h96);
    add(8'h00,0,1,0, 1,0,0,zv96);
    // reset mid-collection
    add(8'h11,1,1,0, 1,0,0,zv96);
    add(8'h22,1,1,0, 1,0,1,zv96);
    add(8'h00,0,1,1, 1,0,1,zv96);
    add(8'h00,0,1,0, 1,0,0,8'h00);
    add(8'h01,1,1,0, 1,0,0,8'h00);
    add(8'h02,1,1,0, 1,0,1,8'h00);
    add(8'h04,1,1,0, 1,0,1,8'h00);
    add(8'h00,0,1,0, 0,0,1,8'h00);
    add(8'h00,0,1,0, 0,1,1,8'h07);
    add(8'h00,0,1,0, 1,0,0,zv07);

    in_reset = 1'b1;
    tick();
    tick();
    check("reset_ready", out_share_ready, 1);
    check("reset_valid", out_value_valid, 0);
    check("reset_value", out_value, 0);
    check("reset_busy", out_busy, 0);
    check("reset_state", out_dbg_state, 0);
    check("reset_count", dut.count_q, 0);
    for (int i = 0; i < 3; i++) check("reset_buffer", dut.buffer_q[i], 0);
    in_reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_share = vecs[i].share;
      in_share_valid = vecs[i].sv;
      in_value_ready = vecs[i].vr;
      in_reset = vecs[i].rst;
      check($sformatf("vec%0d_ready", i), out_share_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_valid", i), out_value_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_busy", i), out_busy, vecs[i].e_busy);
      check($sformatf("vec%0d_value", i), out_value, vecs[i].e_value);
      tick();
    end
    in_reset = 1'b0;
    for (int i = 0; i < 3; i++) check("post_reset_buffer_zero_or_new", dut.buffer_q[i] == 8'h00 || ZEROIZE == 1'b0, 1);

    // gapped input: count moves only on handshakes
    in_value_ready = 1'b1;
    in_share = 8'h80; in_share_valid = 1'b1; check("gap_count0", dut.count_q, 0); tick();
    in_share = 8'hFF; in_share_valid = 1'b0; check("gap_count1", dut.count_q, 1); tick();
    in_share = 8'h40; in_share_valid = 1'b1; check("gap_count1b", dut.count_q, 1); tick();
    in_share = 8'hFF; in_share_valid = 1'b0; check("gap_count2", dut.count_q, 2); tick();
    in_share = 8'h20; in_share_valid = 1'b1; check("gap_count2b", dut.count_q, 2); tick();
    in_share_valid = 1'b0;
    check("gap_count_wrap", dut.count_q, 0);
    check("gap_reduce_ready", out_share_ready, 0);
    tick();
    check("gap_valid", out_value_valid, 1);
    check("gap_value", out_value, 8'hE0);
    tick();
    check("gap_after_value", out_value, zve0);

    // zeroize / retention after the handshake
    in_share = 8'hA5; in_share_valid = 1'b1; tick();
    in_share = 8'h3C; tick();
    in_share = 8'h0F; tick();
    in_share_valid = 1'b0;
    wait_valid(1'b0, ok);
    check("zero_wait_timeout", ok, 1);
    check("zero_value", out_value, 8'h96);
    tick();
    check("zero_after_value", out_value, zv96);
    check("zero_buf0", dut.buffer_q[0], ZEROIZE ? 8'h00 : 8'hA5);
    check("zero_buf1", dut.buffer_q[1], ZEROIZE ? 8'h00 : 8'h3C);
    check("zero_buf2", dut.buffer_q[2], ZEROIZE ? 8'h00 : 8'h0F);

    // minimal shares: zero result still valid
    share2 = 8'hFF; share_valid2 = 1'b1;
    check("min_ready", share_ready2, 1);
    tick();
    tick();
    share_valid2 = 1'b0;
    check("min_busy", busy2, 1);
    check("min_state_not_collect", dbg_state2 != 2'd0, 1);
    wait_valid(1'b1, ok);
    check("min_wait_timeout", ok, 1);
    check("min_valid", value_valid2, 1);
    check("min_value", value2, 8'h00);

    // random traffic against the scoreboard
    in_reset = 1'b1; in_share_valid = 1'b0;
    tick();
    in_reset = 1'b0;
    pending = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; prev_value = '0;
    t_last = -100;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!pending) begin
        in_share = 8'($urandom);
        in_share_valid = ($urandom_range(0, 3) != 0);
      end
      in_value_ready = ($urandom_range(0, 2) != 0);
      acc = in_share_valid && out_share_ready;
      hs = out_value_valid && in_value_ready;
      check("rnd_no_overlap", out_value_valid & out_share_ready, 0);
      if (out_value_valid && !prev_valid) check("rnd_latency", cyc - t_last, 2);
      if (prev_valid && !prev_hs) begin
        check("rnd_hold_valid", out_value_valid, 1);
        check("rnd_hold_value", out_value, prev_value);
      end
      if (prev_hs) begin
        check("rnd_after_hs_ready", out_share_ready, 1);
        check("rnd_after_hs_valid", out_value_valid, 0);
      end
      if (hs) begin
        check("rnd_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rnd_value", out_value, exp_q.pop_front());
      end
      if (acc) begin
        group.push_back(in_share);
        if (group.size() == 3) begin
          acc_x = '0;
          foreach (group[k]) acc_x ^= group[k];
          exp_q.push_back(acc_x);
          group.delete();
          t_last = cyc;
        end
      end
      pending = in_share_valid && !acc;
      prev_valid = out_value_valid;
      prev_hs = hs;
      prev_value = out_value;
      tick();
    end
    in_share_valid = 1'b0;
    in_value_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_value_valid) begin
        check("drain_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("drain_value", out_value, exp_q.pop_front());
      end
      tick();
    end
    check("drain_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unmask_sequencer.md
# unmask_sequencer

Collects the `NUM_SHARES` shares of one masked value serially over a valid/ready stream and buffers them. Once every share is held, it recombines them through one registered `reduce_xor` stage and presents the unmasked value on a valid/ready output. It sits at the boundary between masked datapaths and unmasked consumers (result readout, debug ports). It guarantees that shares of a value meet in only one registered XOR tree, and only after all of them have arrived.

## Interface
Parameters:
- `NUM_SHARES`, 3, number of shares per masked value; must be at least 2.
- `ELEMENT_WIDTH`, 8, width of each share and of the result, in bits.

Ports:
- `in_clock`  input  1  the single clock; all logic is rising-edge.
- `in_reset`  input  1  reset; synchronous, active-high.
- `in_share`  input  `ELEMENT_WIDTH`  incoming share.
- `in_share_valid`  input  1  `in_share` is valid this cycle.
- `out_share_ready`  output  1  block accepts a share this cycle.
- `out_value`  output  `ELEMENT_WIDTH`  unmasked value, the XOR of all buffered shares.
- `out_value_valid`  output  1  `out_value` is valid.
- `in_value_ready`  input  1  consumer accepts `out_value`.
- `out_busy`  output  1  high whenever the state is not `COLLECT` or the share count is non-zero.

## Operation
- State machine states: `COLLECT`, `REDUCE`, `OUTPUT`. Reset state is `COLLECT`.
- **`COLLECT`:**
  - `out_share_ready` is 1.
  - On `in_share_valid & out_share_ready`, `in_share` is written to `buffer[count]` and `count` increments.
  - The share count register is `$clog2(NUM_SHARES+1)` bits wide.
  - When the accepted share is share index `NUM_SHARES-1`, the next state is `REDUCE` and `count` returns to 0.
- **`REDUCE`:**
  - Lasts exactly one cycle, with `out_share_ready` at 0.
  - `out_value` is registered as the XOR of all buffer entries, computed by the `reduce_xor` instance.
  - The next state is `OUTPUT`.
- **`OUTPUT`:**
  - `out_value_valid` is 1 and `out_share_ready` is 0.
  - `out_value` stays stable until `in_value_ready` is sampled high.
  - On that handshake the next state is `COLLECT`.
- Shares presented while `out_share_ready` is 0 are not consumed. The upstream side must hold them, as normal valid/ready.
- **Reset mid-operation:** any partial collection or pending output is discarded, and the block returns to reset values on the next edge.
- **Reset values:**
  - `out_share_ready` = 1
  - `out_value_valid` = 0
  - `out_value` = 0
  - `out_busy` = 0
  - `count` = 0
  - every buffer entry = 0
- `in_share` is captured only on the handshake. The buffer never changes while in `REDUCE` or `OUTPUT`.

## Timing
- If the last share is accepted in cycle t, the state is `REDUCE` in t+1 and `out_value_valid` rises in t+2.
- Minimum period per result is `NUM_SHARES + 2` cycles: `NUM_SHARES` collect cycles, 1 reduce cycle, and 1 output cycle when `in_value_ready` is already high.
- The output handshake in cycle u means `out_value_valid` = 0 and `out_share_ready` = 1 in u+1. There is no same-cycle overlap of output and collection.
- `out_value` is register-driven with no combinational path from any input. `out_share_ready` depends only on state.

## Configuration
- Macro `UNMASK_SEQUENCER_ZEROIZE_EN`.
- **Defined:**
  - All buffer entries and `out_value` are cleared to 0 in the cycle after the output handshake.
  - `out_value` therefore reads 0 whenever `out_value_valid` is 0 after the first result.
- **Undefined:**
  - Buffer and `out_value` retain their last contents until they are overwritten.
  - No clearing logic is generated.

## Structure
- Package `unmask_sequencer_pkg` holds the state enum (`COLLECT`, `REDUCE`, `OUTPUT`).
- Element and share-array typedefs are derived inside the module from `ELEMENT_WIDTH`.
- One sub-module, the existing `reduce_xor`, instantiated with:
  - `NUM_ELEMENTS = NUM_SHARES`
  - `ELEMENT_WIDTH = ELEMENT_WIDTH`
- `reduce_xor` takes the share buffer as input, and its output feeds the `out_value` register.

## Test plan
- **Basic recombination** (`NUM_SHARES`=3, width 8, `in_value_ready` held high): shares 0xA5, 0x3C, 0x0F are sent back-to-back from cycle 0. Required response:
  - `out_value` = 0x96 with valid in cycle 4.
  - `out_share_ready` = 0 in cycles 3–4.
  - `out_share_ready` = 1 again in cycle 5.
- **Backpressure:** same shares, with `in_value_ready` low for 5 cycles. Required response:
  - `out_value` stays 0x96 and valid stays 1 throughout.
  - `out_share_ready` stays 0.
  - Shares offered meanwhile are not consumed.
- **Reset mid-collection:** after 2 shares (0x11, 0x22), pulse `in_reset` for one cycle, then send 0x01, 0x02, 0x04. Required response:
  - All outputs return to their reset values after the reset edge.
  - The result is 0x07.
- **Gapped input:** `in_share_valid` toggles 1/0 with shares 0x80, 0x40, 0x20. Required response:
  - The result is 0xE0.
  - `count` advances only on handshakes.
- **Minimal shares** (`NUM_SHARES`=2): shares 0xFF, 0xFF. Required response: the result is 0x00 with valid asserted, i.e. a zero result is still signalled as valid.
- **Zeroize** (macro defined): after the 0x96 handshake, check that `out_value` = 0 and all buffer entries = 0 in the next cycle. Without the macro, check that `out_value` remains 0x96.
